// File: rtl/dmem_lsu.sv
// Load/store unit for the MEM stage: splits word-crossing accesses into two
// word accesses, builds byte masks and lane-aligned data, and reassembles loads.
`timescale 1ns/1ps

module dmem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ceb,
    output logic        mem_web,
    output logic [9:0]  mem_A,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_D,
    input  logic [31:0] mem_Q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_hold;

    logic        w_accept;
    logic [1:0]  w_off;
    logic [4:0]  w_sh;
    logic [3:0]  w_bmask;
    logic [7:0]  w_lanes;
    logic        w_split;
    logic [31:0] w_rot;
    logic [31:0] w_first;
    logic [31:0] w_second;
    logic [63:0] w_pair;
    logic [31:0] w_shifted;
    logic        w_sign;
    logic [31:0] w_load;

    assign w_accept = req_valid && req_ready;
    assign w_off    = r_addr[1:0];
    assign w_sh     = {w_off, 3'b000};

    always_comb begin
        case (r_size)
            SIZE_B:  w_bmask = 4'b0001;
            SIZE_H:  w_bmask = 4'b0011;
            default: w_bmask = 4'b1111;
        endcase
    end

    // Lanes 3:0 belong to the first word, lanes 7:4 spill into the next word.
    assign w_lanes = {4'b0000, w_bmask} << w_off;
    assign w_split = |w_lanes[7:4];
    assign w_rot   = (r_wdata << w_sh) | (r_wdata >> (6'd32 - {1'b0, w_sh}));

    // On a split load the last read (mem_Q) is the upper word of the pair.
    assign w_first   = w_split ? r_hold : mem_Q;
    assign w_second  = w_split ? mem_Q : 32'd0;
    assign w_pair    = {w_second, w_first};
    assign w_shifted = 32'(w_pair >> w_sh);

    always_comb begin
        w_sign = !r_unsigned && ((r_size == SIZE_B) ? w_shifted[7] : w_shifted[15]);
        case (r_size)
            SIZE_B:  w_load = {{24{w_sign}}, w_shifted[7:0]};
            SIZE_H:  w_load = {{16{w_sign}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) r_state <= (req_size == SIZE_ILL) ? S_DONE : S_ACC1;
                S_ACC1: r_state <= w_split ? S_ACC2 : S_DONE;
                S_ACC2: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: request and holding registers carry no reset; they are only read in
    // states reachable after a capture, so their power-up value never escapes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
        end
        if (r_state == S_ACC2) r_hold <= mem_Q;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        req_ready = (r_state == S_IDLE) && !reset;
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        mem_ceb   = 1'b1;
        mem_web   = 1'b1;
        mem_A     = 10'd0;
        mem_mask  = 4'b0000;
        mem_D     = 32'd0;
        case (r_state)
            S_ACC1: begin
                mem_ceb  = 1'b0;
                mem_web  = !r_we;
                mem_A    = r_addr[11:2];
                mem_mask = r_we ? w_lanes[3:0] : 4'b0000;
                mem_D    = w_rot;
            end
            S_ACC2: begin
                mem_ceb  = 1'b0;
                mem_web  = !r_we;
                mem_A    = r_addr[11:2] + 10'd1;
                mem_mask = r_we ? w_lanes[7:4] : 4'b0000;
                mem_D    = w_rot;
            end
            S_DONE: begin
                rsp_valid = !reset;
                if (r_size == SIZE_ILL) rsp_err = 1'b1;
                else if (!r_we)         rsp_rdata = w_load;
            end
            default: ;
        endcase
        // A reset cycle must never issue a memory write.
        if (reset) mem_ceb = 1'b1;
    end

endmodule
